// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the bolometer matrix scan sequencer.
//   scan_state_e : sequencer states
//   AdcErrFill   : sample value reported when a conversion times out
//                  (slice the low AdcW bits)
package matrix_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CONV   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4
  } scan_state_e;

  localparam int unsigned MaxAdcW = 64;
  localparam logic [MaxAdcW-1:0] AdcErrFill = '1;

endpackage

// File: rtl/matrix_scan_ctrl_delay_cnt.sv
// Loadable saturating down-counter used for the settle and ADC-timeout delays.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over counting)
//   load_val : start value
//   en       : count down by one (holds at zero)
//   last     : count is at its final cycle (<= 1)
module scan_delay_cnt #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            en,
  output logic            last
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Loaded with N, the state using this counter lasts N cycles: the
  // transition fires in the cycle where the count reads 1.
  assign last = (cnt_q <= CntW'(1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for the bolometer pixel mux matrix. Steps row/column
// addresses, waits for the analog path to settle, requests one ADC
// conversion per pixel and forwards each sample tagged with its address.
//   clk_i/rst_ni       : clock, asynchronous active-low reset
//   start_i/stop_i     : start one frame (IDLE only) / abort to IDLE
//   col_step_o         : strobe advancing the external column counter
//   row_o/col_o        : current pixel address
//   adc_start_o        : conversion request strobe
//   adc_done_i/_data_i : conversion complete pulse and its result
//   pix_data_o/_row_o/_col_o/_valid_o : tagged sample and its strobe
//   frame_done_o       : strobe alongside the last pixel of a frame
//   busy_o             : high outside IDLE
//   err_o              : sticky ADC-timeout flag, cleared by start
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int unsigned Rows          = 2,
  parameter int unsigned Cols          = 2,
  parameter int unsigned Width         = 5,
  parameter int unsigned AdcW          = 16,
  parameter int unsigned SettleCycles  = 100,
  parameter int unsigned TimeoutCycles = 1024,
  parameter bit          Continuous    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             col_step_o,
  output logic [Width-1:0] row_o,
  output logic [Width-1:0] col_o,
  output logic             adc_start_o,
  input  logic             adc_done_i,
  input  logic [AdcW-1:0]  adc_data_i,
  output logic [AdcW-1:0]  pix_data_o,
  output logic [Width-1:0] pix_row_o,
  output logic [Width-1:0] pix_col_o,
  output logic             pix_valid_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned SetW = $clog2(SettleCycles) + 1;
  localparam int unsigned ToW  = $clog2(TimeoutCycles) + 1;
  localparam logic [Width-1:0] LastRow = Width'(Rows - 1);
  localparam logic [Width-1:0] LastCol = Width'(Cols - 1);

  scan_state_e state_q, state_d;
  logic [Width-1:0] row_q, col_q, row_d, col_d;
  logic settle_load, settle_last, to_load, to_last;
  logic last_col, last_pix;

  logic             store_d, adc_start_d, busy_d, frame_done_d, err_d;
  logic [AdcW-1:0]  pix_data_d;
  logic             col_step_q, adc_start_q, pix_valid_q, frame_done_q, busy_q, err_q;
  logic [AdcW-1:0]  pix_data_q;
  logic [Width-1:0] pix_row_q, pix_col_q;

  assign last_col = (col_q == LastCol);
  assign last_pix = last_col && (row_q == LastRow);

  // Counters load on entry to the state they time.
  assign settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
  assign to_load     = (state_q == ST_CONV) && (state_d == ST_WAIT);

  scan_delay_cnt #(.CntW(SetW)) u_settle_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (settle_load),
    .load_val (SetW'(SettleCycles)),
    .en       (state_q == ST_SETTLE),
    .last     (settle_last)
  );

  scan_delay_cnt #(.CntW(ToW)) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (to_load),
    .load_val (ToW'(TimeoutCycles)),
    .en       (state_q == ST_WAIT),
    .last     (to_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start_i) state_d = ST_SETTLE;
        ST_SETTLE: if (settle_last) state_d = ST_CONV;
        ST_CONV:   state_d = ST_WAIT;
        ST_WAIT:   if (adc_done_i || to_last) state_d = ST_STORE;
        ST_STORE:  state_d = (last_pix && !Continuous) ? ST_IDLE : ST_SETTLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the upcoming state so each strobe is high
  // during the state it belongs to; adc_start_o follows CONV by one clock.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (stop_i || (state_q == ST_IDLE && start_i)) begin
      row_d = '0;
      col_d = '0;
    end else if (state_q == ST_STORE) begin
      if (last_pix) begin
        row_d = '0;
        col_d = '0;
      end else if (last_col) begin
        row_d = row_q + Width'(1);
        col_d = '0;
      end else begin
        col_d = col_q + Width'(1);
      end
    end

    store_d      = (state_d == ST_STORE);
    adc_start_d  = to_load;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = store_d && last_pix;
    pix_data_d   = adc_done_i ? adc_data_i : AdcErrFill[AdcW-1:0];

    err_d = err_q;
    if (state_q == ST_IDLE && state_d == ST_SETTLE) begin
      err_d = 1'b0;
    end else if (store_d && !adc_done_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q        <= '0;
      col_q        <= '0;
      col_step_q   <= 1'b0;
      adc_start_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      pix_data_q   <= '0;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      col_step_q   <= store_d;
      adc_start_q  <= adc_start_d;
      pix_valid_q  <= store_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      if (store_d) begin
        pix_data_q <= pix_data_d;
        pix_row_q  <= row_q;
        pix_col_q  <= col_q;
      end
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign col_step_o   = col_step_q;
  assign adc_start_o  = adc_start_q;
  assign pix_valid_o  = pix_valid_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign pix_data_o   = pix_data_q;
  assign pix_row_o    = pix_row_q;
  assign pix_col_o    = pix_col_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
module tb_matrix_scan_ctrl;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int SETTLE = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i, stop_i;
  logic adc_done_i;
  logic [15:0] adc_data_i;

  logic col_step_o, adc_start_o, pix_valid_o, frame_done_o, busy_o, err_o;
  logic [4:0] row_o, col_o, pix_row_o, pix_col_o;
  logic [15:0] pix_data_o;

  logic c_col_step_o, c_adc_start_o, c_pix_valid_o, c_frame_done_o, c_busy_o, c_err_o;
  logic [4:0] c_row_o, c_col_o, c_pix_row_o, c_pix_col_o;
  logic [15:0] c_pix_data_o;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .Rows(ROWS), .Cols(COLS), .Width(5), .AdcW(16),
    .SettleCycles(SETTLE), .TimeoutCycles(TMO), .Continuous(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .stop_i(stop_i),
    .col_step_o(col_step_o), .row_o(row_o), .col_o(col_o),
    .adc_start_o(adc_start_o), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
    .pix_data_o(pix_data_o), .pix_row_o(pix_row_o), .pix_col_o(pix_col_o),
    .pix_valid_o(pix_valid_o), .frame_done_o(frame_done_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  matrix_scan_ctrl #(
    .Rows(ROWS), .Cols(COLS), .Width(5), .AdcW(16),
    .SettleCycles(SETTLE), .TimeoutCycles(TMO), .Continuous(1'b1)
  ) dut_cont (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .stop_i(stop_i),
    .col_step_o(c_col_step_o), .row_o(c_row_o), .col_o(c_col_o),
    .adc_start_o(c_adc_start_o), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
    .pix_data_o(c_pix_data_o), .pix_row_o(c_pix_row_o), .pix_col_o(c_pix_col_o),
    .pix_valid_o(c_pix_valid_o), .frame_done_o(c_frame_done_o),
    .busy_o(c_busy_o), .err_o(c_err_o)
  );

  typedef struct {
    logic [4:0]  row;
    logic [4:0]  col;
    logic [15:0] data;
    logic        last;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int mode = 1;       // 0 random ADC, 1 fixed 3-cycle reply, 2 never reply, 3 stop scenario
  int frame_seq = 0;  // bumped by stimulus on every start
  int pix_seen = 0;
  int cs_cnt = 0;
  logic err_model = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ADC reference: pixel order is raster order, one expected sample per request.
  initial begin : responder
    int pix_idx;
    int seen_seq;
    int d;
    exp_t e;
    pix_idx = 0;
    seen_seq = -1;
    adc_done_i = 1'b0;
    adc_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && adc_start_o) begin
        if (frame_seq != seen_seq) begin
          seen_seq = frame_seq;
          pix_idx = 0;
          err_model = 1'b0;
        end
        e.row  = 5'(pix_idx / COLS);
        e.col  = 5'(pix_idx % COLS);
        e.last = (pix_idx == ROWS * COLS - 1);
        case (mode)
          0: d = $urandom_range(0, 8);
          1: d = 3;
          2: d = 8;
          default: d = (pix_idx == 0) ? 8 : (pix_idx == 2) ? -1 : 3;
        endcase
        if (d < 0) begin
          // stop lands before this; reply arrives after the abort
          repeat (4) @(negedge clk);
          adc_done_i = 1'b1;
          adc_data_i = 16'h5555;
          @(negedge clk);
          adc_done_i = 1'b0;
        end else begin
          if (d <= TMO - 1) begin
            e.data = (mode == 0) ? 16'($urandom) : 16'hA000 + 16'(pix_idx);
            e.err  = err_model;
            e.lat  = SETTLE + 1 + d + 1;
          end else begin
            err_model = 1'b1;
            e.data = 16'hFFFF;
            e.err  = 1'b1;
            e.lat  = SETTLE + 1 + TMO;
          end
          exp_q.push_back(e);
          repeat (d) @(negedge clk);
          // d == TMO: a reply one cycle too late, which must be ignored
          adc_done_i = 1'b1;
          adc_data_i = (d <= TMO - 1) ? e.data : 16'h1234;
          @(negedge clk);
          adc_done_i = 1'b0;
          adc_data_i = 16'($urandom);
        end
        pix_idx = (pix_idx + 1) % (ROWS * COLS);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int t;
    logic busy_prev, pv_prev, fd_prev;
    t = 0;
    busy_prev = 1'b0;
    pv_prev = 1'b0;
    fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
        pv_prev = 1'b0;
        fd_prev = 1'b0;
      end else begin
        // t counts clocks since the current address was applied
        if (busy_o && (!busy_prev || pv_prev)) t = 0;
        else if (t < 100000) t++;
        if (adc_start_o) chk("addr_to_adc_start", 64'(t), 64'(SETTLE + 1));
        if (fd_prev) chk("busy_after_frame", busy_o, 0);
        if (col_step_o) cs_cnt++;
        if (pix_valid_o) begin
          pix_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got (%0d,%0d)=%0h expected none", pix_row_o, pix_col_o, pix_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("pix_data", pix_data_o, e.data);
            chk("pix_addr", {pix_row_o, pix_col_o}, {e.row, e.col});
            chk("frame_done", frame_done_o, e.last);
            chk("err", err_o, e.err);
            chk("col_step", col_step_o, 1);
            chk("pixel_latency", 64'(t), 64'(e.lat));
          end
        end else if (frame_done_o || col_step_o) begin
          chk("strobe_without_pixel", {frame_done_o, col_step_o}, 0);
        end
        busy_prev = busy_o;
        pv_prev = pix_valid_o;
        fd_prev = frame_done_o;
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    frame_seq++;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("frame_completes", busy_o, 0);
  endtask

  task automatic wait_pixels(input int target);
    int n = 0;
    while (pix_seen < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("pixels_arrive", 64'(pix_seen >= target), 1);
  endtask

  initial begin : stimulus
    int n;
    int cs0;
    int base;
    rst_n = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    #7;
    chk("reset_outputs", {busy_o, err_o, row_o, col_o, pix_data_o, pix_row_o, pix_col_o,
                          pix_valid_o, frame_done_o, col_step_o, adc_start_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed frame with fixed ADC replies; continuous twin checked at wrap.
    mode = 1;
    cs0 = cs_cnt;
    start_frame();
    n = 0;
    while (!frame_done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", frame_done_o, 1);
    chk("cont_frame_done", c_frame_done_o, 1);
    @(negedge clk);
    chk("cont_stays_busy", c_busy_o, 1);
    chk("cont_addr_reset", {c_row_o, c_col_o}, 0);
    n = 0;
    while (!c_adc_start_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cont_restart_delay", 64'(n), 64'(SETTLE + 1));
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("cont_stopped", c_busy_o, 0);
    chk("col_steps_per_frame", 64'(cs_cnt - cs0), 64'(ROWS * COLS));

    // ADC never answers: every pixel times out, scan still completes.
    mode = 2;
    start_frame();
    wait_idle();
    chk("err_sticky", err_o, err_model);
    mode = 1;
    start_frame();
    chk("err_cleared_by_start", err_o, 0);
    wait_idle();

    // Randomised reply delays, including late replies past the timeout.
    for (int f = 0; f < 8; f++) begin
      mode = 0;
      start_frame();
      wait_idle();
      chk("err_after_random_frame", err_o, err_model);
    end

    // Abort mid-WAIT of pixel (1,0); the late reply must produce nothing.
    mode = 3;
    base = pix_seen;
    start_frame();
    wait_pixels(base + 2);
    n = 0;
    while (!adc_start_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stop_pixel_requested", adc_start_o, 1);
    repeat (2) @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_busy", busy_o, 0);
    chk("stop_addr", {row_o, col_o}, 0);
    chk("stop_no_pixel", pix_valid_o, 0);
    chk("stop_err_holds", err_o, err_model);
    repeat (12) @(negedge clk);
    chk("stop_stays_idle", busy_o, 0);

    // Asynchronous reset between edges in the middle of SETTLE.
    mode = 1;
    base = pix_seen;
    start_frame();
    wait_pixels(base + 2);
    @(negedge clk);
    chk("pre_reset_addr", {row_o, col_o}, {5'd1, 5'd0});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy_o, err_o, row_o, col_o, pix_data_o, pix_row_o, pix_col_o,
                                pix_valid_o, frame_done_o, col_step_o, adc_start_o}, 0);
    chk("async_reset_cont", {c_busy_o, c_err_o, c_row_o, c_col_o, c_pix_data_o, c_pix_row_o,
                             c_pix_col_o, c_pix_valid_o, c_frame_done_o, c_col_step_o,
                             c_adc_start_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_resume_without_start", {busy_o, adc_start_o}, 0);

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
